// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one N-bit adder among NREQ requesters.
// Each accepted operation lands in a one-entry result slot drained by valid/ready.
module shared_adder_arbiter #(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_sum,
    output logic                 res_carry,
    output logic                 res_overflow,
    output logic [IDW-1:0]       res_id
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [IDW-1:0]  r_ptr;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic            r_ovf;
    logic [IDW-1:0]  r_id;

    logic            w_free;
    logic            w_found;
    logic            w_grant;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_best;
    logic [IDW-1:0]  w_dist [NREQ];
    logic [IDW-1:0]  w_ptr_next;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [N:0]      w_sum_ext;
    logic            w_ovf;

    assign w_free = (r_state == ST_EMPTY) || res_ready;

    // Distance of each requester from the priority pointer; smallest valid distance wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dist
            assign w_dist[gi] = IDW'((gi + NREQ - int'(r_ptr)) % NREQ);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (!w_found || (w_dist[i] < w_best))) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
                w_best  = w_dist[i];
            end
        end
    end

    // Gating with rst keeps req_ready low while the block is held in reset.
    assign w_grant = w_free && w_found && !rst;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = w_grant && (w_win == IDW'(gi));
        end
    endgenerate

    assign w_a        = req_a[w_win*N +: N];
    assign w_b        = req_b[w_win*N +: N];
    assign w_sum_ext  = {1'b0, w_a} + {1'b0, w_b};
    assign w_ovf      = (w_a[N-1] == w_b[N-1]) && (w_sum_ext[N-1] != w_a[N-1]);
    assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_next = ST_FULL;
            ST_FULL: begin
                if (res_ready) begin
                    w_state_next = w_grant ? ST_FULL : ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_ptr   <= w_ptr_next;
                r_sum   <= w_sum_ext[N-1:0];
                r_carry <= w_sum_ext[N];
                r_ovf   <= w_ovf;
                r_id    <= w_win;
            end
        end
    end

    assign res_valid    = (r_state == ST_FULL);
    assign res_sum      = r_sum;
    assign res_carry    = r_carry;
    assign res_overflow = r_ovf;
    assign res_id       = r_id;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Randomized scoreboard bench for shared_adder_arbiter with directed corner cases.
module tb_shared_adder_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [N-1:0]        res_sum;
    logic                res_carry;
    logic                res_overflow;
    logic [IDW-1:0]      res_id;

    logic [N-1:0] op_a [NREQ];
    logic [N-1:0] op_b [NREQ];

    typedef struct {
        int sum;
        int carry;
        int ovf;
        int id;
    } res_t;

    res_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_ptr = 0;
    bit   m_full = 1'b0;
    int   last_win = -1;

    shared_adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry(res_carry),
        .res_overflow(res_overflow), .res_id(res_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = op_a[i];
            req_b[i*N +: N] = op_b[i];
        end
    end

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers: unsigned total and signed range test.
    function automatic res_t model_add(int a, int b, int id);
        res_t r;
        int total, sa, sb, ssum;
        total   = a + b;
        r.sum   = total % (1 << N);
        r.carry = total / (1 << N);
        sa      = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        sb      = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        ssum    = sa + sb;
        r.ovf   = ((ssum > (1 << (N-1)) - 1) || (ssum < -(1 << (N-1)))) ? 1 : 0;
        r.id    = id;
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'hFF;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'h00;
            default: return N'($urandom);
        endcase
    endfunction

    task automatic set_op(int i, logic [N-1:0] a, logic [N-1:0] b);
        op_a[i] = a;
        op_b[i] = b;
    endtask

    // One clock: predict the winner from the rotating priority, check req_ready,
    // queue the expected result, then advance the model across the edge.
    task automatic step();
        int  win;
        int  idx;
        bit  free;
        logic [NREQ-1:0] exp_rdy;
        #2;
        free = !m_full || res_ready;
        win  = -1;
        if (free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        if (win >= 0) q.push_back(model_add(int'(op_a[win]), int'(op_b[win]), win));
        @(posedge clk);
        if (win >= 0) begin
            m_full = 1'b1;
            m_ptr  = (win + 1) % NREQ;
        end else if (res_ready) begin
            m_full = 1'b0;
        end
        last_win = win;
        #1;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            chk("res_valid", int'(res_valid), int'(m_full));
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    e = q.pop_front();
                    $display("[TB] result id=%0d sum=%02h c=%0d v=%0d", res_id, res_sum, res_carry, res_overflow);
                    chk("res_sum", int'(res_sum), e.sum);
                    chk("res_carry", int'(res_carry), e.carry);
                    chk("res_overflow", int'(res_overflow), e.ovf);
                    chk("res_id", int'(res_id), e.id);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) set_op(i, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_sum", int'(res_sum), 0);
        chk("rst_res_id", int'(res_id), 0);
        rst = 1'b0;
        step();
        step();

        // Round-robin with everyone continuously valid
        for (int i = 0; i < NREQ; i++) set_op(i, pick(), pick());
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_order", last_win, k % NREQ);
            if (last_win >= 0) set_op(last_win, pick(), pick());
        end
        req_valid = '0;
        step();

        // Single add 0x7F + 0x01 from requester 2
        set_op(2, 8'h7F, 8'h01);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("add_sum", int'(res_sum), 8'h80);
        chk("add_carry", int'(res_carry), 0);
        chk("add_ovf", int'(res_overflow), 1);
        chk("add_id", int'(res_id), 2);
        step();

        // Carry / wrap cases
        set_op(1, 8'hFF, 8'h01);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("wrap_sum", int'(res_sum), 0);
        chk("wrap_carry", int'(res_carry), 1);
        chk("wrap_ovf", int'(res_overflow), 0);
        set_op(3, 8'h80, 8'h80);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        chk("neg_sum", int'(res_sum), 0);
        chk("neg_carry", int'(res_carry), 1);
        chk("neg_ovf", int'(res_overflow), 1);
        step();

        // Backpressure: slot held for 3 cycles with requests pending
        set_op(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        step();
        res_ready = 1'b0;
        set_op(1, 8'h55, 8'h2B);
        set_op(3, 8'hC0, 8'hC0);
        req_valid = 4'b1010;
        repeat (3) step();
        chk("bp_sum_held", int'(res_sum), 8'h46);
        res_ready = 1'b1;
        step();
        chk("bp_first_grant", last_win, 1);
        req_valid = 4'b1000;
        step();
        chk("bp_second_grant", last_win, 3);
        req_valid = '0;
        step();

        // Drain to empty, then an immediate grant to requester 0
        step();
        chk("drain_empty", int'(res_valid), 0);
        set_op(0, 8'h01, 8'h02);
        req_valid = 4'b0001;
        step();
        chk("drain_regrant", last_win, 0);
        req_valid = '0;
        chk("drain_sum", int'(res_sum), 3);
        step();

        // Reset while a result is pending and all requesters are waiting
        set_op(2, 8'h10, 8'h20);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(res_valid), 0);
        chk("midrst_sum", int'(res_sum), 0);
        chk("midrst_id", int'(res_id), 0);
        chk("midrst_ready", int'(req_ready), 0);
        q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        step();
        step();

        // Randomized traffic with backpressure and abandoned requests
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_win == i) begin
                    if ($urandom_range(0, 3) != 0) set_op(i, pick(), pick());
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_op(i, pick(), pick());
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) step();
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
Shares a single N-bit adder datapath (sum, carry-out, signed overflow) among NREQ requesters. Requests are arbitrated round-robin, with a valid/ready handshake on each requester port. Each result is registered into a one-entry output slot, tagged with the requester index, and drained through a valid/ready result interface. The block sits between several client engines and the common adder resource.

Parameters:
N, 8, operand/sum width in bits (N >= 2)
NREQ, 4, number of requesters (2..16); ID width IDW = clog2(NREQ), localparam, minimum 1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  NREQ*N  operand A; requester i at [i*N +: N]
req_b  input  NREQ*N  operand B; requester i at [i*N +: N]
res_valid  output  1  result slot holds a valid result
res_ready  input  1  consumer accepts result
res_sum  output  N  registered sum[N-1:0]
res_carry  output  1  registered unsigned carry-out
res_overflow  output  1  registered signed (two's-complement) overflow
res_id  output  IDW  index of requester that owns the result

Behaviour:
- Reset (async assert, sync-safe release): res_valid=0, res_sum=0, res_carry=0, res_overflow=0, res_id=0, priority pointer=0 (requester 0 highest). req_ready is combinational and is therefore 0 while reset is asserted.
- Slot free condition: free = !res_valid || res_ready.
- Grant logic (combinational): when free, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1. req_ready = one-hot of the winner; all zero if not free or no request pending.
- Transfer occurs on req_valid[i] && req_ready[i]. On the next edge:
  - Slot loads {res_carry, res_sum} = zero-extended a + b (N+1 bits).
  - res_overflow = (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]).
  - res_id = i; res_valid = 1; ptr = (i+1) mod NREQ.
- Latency: result is visible exactly 1 cycle after the accepting edge.
- Throughput: 1 result/cycle when res_ready is held high (drain and refill on the same edge).
- Drain without refill: res_valid && res_ready with no grant clears res_valid on the next edge. res_sum, res_carry, res_overflow and res_id hold their last values.
- Backpressure: res_valid && !res_ready means no grant and all outputs stable. Requesters must hold req_valid, req_a and req_b stable until accepted; dropping req_valid before acceptance is allowed and is simply not granted.
- Pointer moves only on a grant. Idle cycles leave it unchanged.
- Fairness: with all requesters continuously valid and res_ready=1, grant order is 0,1,...,NREQ-1,0,... Any requester waits at most NREQ-1 grants.
- Wrap-around: a grant to NREQ-1 sets ptr=0.
- Arithmetic wrap: sum is modulo 2^N; the carry bit captures the overflowed bit.
- Reset mid-operation: any pending result is discarded (res_valid=0). Any request that is valid but not yet accepted is not acknowledged and must be re-presented by the requester.
- State machine, 2 states keyed on res_valid:
  - EMPTY -> FULL on grant.
  - FULL -> FULL on res_ready && grant.
  - FULL -> EMPTY on res_ready && no grant.
  - FULL holds on !res_ready.
- No combinational path from req_a/req_b to any output. The path from res_ready to req_ready is allowed.

Test Plan:
- Reset/idle: assert rst mid-cycle with res_valid=1 -> all outputs 0 immediately; after release with no req_valid, req_ready=0 and res_valid stays 0.
- Single add, N=8: req 2 sends a=0x7F, b=0x01 with res_ready=1 -> req_ready=0b0100 that cycle; next cycle res_sum=0x80, carry=0, overflow=1, res_id=2.
- Carry/wrap: a=0xFF, b=0x01 -> sum=0x00, carry=1, overflow=0. Also a=0x80, b=0x80 -> sum=0x00, carry=1, overflow=1.
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows one cycle later; each result matches that requester's operands.
- Backpressure: result held with res_ready=0 for 3 cycles while req 1 and req 3 are valid -> req_ready=0 and outputs stable throughout. Raise res_ready -> drain and grant on the same edge; pointer order is preserved.
- Drain to empty: single result, res_ready=1, no new requests -> res_valid falls after one cycle; the next request from req 0 gets an immediate grant and its result the following cycle.
